// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32I core definitions used by the hazard controller,
//               the ID/EX operand latch and the memory stage.
//               - MEMOP_* : memOp encoding carried in the ID/EX latch
//               - ctrl_state_e : pipeline-control state encoding
//               - is_mem_op()  : true for ops that occupy data memory
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } ctrl_state_e;

  // The reserved encoding 2'b11 behaves like MEMOP_NONE.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational load-use comparator. Flags when the
//               instruction in decode reads the destination of a load that
//               is currently held in the ID/EX latch.
// Ports       : idValid_i        decode holds a real instruction
//               idRs1_i/idRs2_i  decode source registers
//               idUseRs1_i/2_i   decode reads rs1 / rs2
//               exMemOp_i        memOp held in ID/EX
//               exRd_i           rd held in ID/EX
//               loadUse_o        load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import core_pkg::*;
(
  input  logic       idValid_i,
  input  logic [4:0] idRs1_i,
  input  logic [4:0] idRs2_i,
  input  logic       idUseRs1_i,
  input  logic       idUseRs2_i,
  input  logic [1:0] exMemOp_i,
  input  logic [4:0] exRd_i,
  output logic       loadUse_o
);

  logic rs1Hit;
  logic rs2Hit;

  assign rs1Hit = idUseRs1_i && (idRs1_i == exRd_i);
  assign rs2Hit = idUseRs2_i && (idRs2_i == exRd_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign loadUse_o = idValid_i && (exMemOp_i == MEMOP_LOAD) &&
                     (exRd_i != 5'd0) && (rs1Hit || rs2Hit);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush control for the IF/ID and ID/EX latches.
//               Handles load-use bubbles, multi-cycle data-memory waits,
//               control-flow redirects (including ones arriving mid-wait),
//               a sticky memory-timeout flag and a stall-cycle counter.
// Ports       : clk, reset_n (async, active low)
//               idValid, idRs1, idRs2, idUseRs1, idUseRs2  decode operands
//               exMemOp, exRd                               ID/EX contents
//               dmemReady                                   dmem completes
//               redirect                                    taken CF in EX
//               stallPc, stallIfId, stallIdEx               hold controls
//               flushIfId, flushIdEx                        bubble controls
//               memTimeout                                  sticky timeout
//               stallCycles                                 sat. stall count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idValid,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUseRs1,
  input  logic             idUseRs2,
  input  logic [1:0]       exMemOp,
  input  logic [4:0]       exRd,
  input  logic             dmemReady,
  input  logic             redirect,
  output logic             stallPc,
  output logic             stallIfId,
  output logic             stallIdEx,
  output logic             flushIfId,
  output logic             flushIdEx,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int               WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WAIT_ONE = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  ctrl_state_e       state_q,       state_d;
  logic [WCNT_W-1:0] waitCnt_q,     waitCnt_d;
  logic              redirPend_q,   redirPend_d;
  logic              memTimeout_q,  memTimeout_d;
  logic [CNT_W-1:0]  stallCycles_q, stallCycles_d;

  logic loadUse;
  logic memBusy;
  logic stallAll;
  logic flushAll;
  logic luBubble;

  hazard_detect u_hazard_detect (
    .idValid_i  (idValid),
    .idRs1_i    (idRs1),
    .idRs2_i    (idRs2),
    .idUseRs1_i (idUseRs1),
    .idUseRs2_i (idUseRs2),
    .exMemOp_i  (exMemOp),
    .exRd_i     (exRd),
    .loadUse_o  (loadUse)
  );

  assign memBusy = is_mem_op(exMemOp) && !dmemReady;

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    redirPend_d = redirPend_q;
    stallAll    = 1'b0;
    flushAll    = 1'b0;
    luBubble    = 1'b0;

    case (state_q)
      RUN: begin
        if (memBusy) begin
          stallAll    = 1'b1;
          state_d     = MEMWAIT;
          waitCnt_d   = WAIT_ONE;
          redirPend_d = redirect;
        end else if (redirect) begin
          flushAll = 1'b1;
        end else if (loadUse) begin
          luBubble = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!dmemReady) begin
          stallAll = 1'b1;
          if (waitCnt_q != WAIT_MAX) begin
            waitCnt_d = waitCnt_q + WAIT_ONE;
          end
          if (redirect) begin
            redirPend_d = 1'b1;
          end
        end else begin
          // The redirect is released only once the frozen pipe moves again.
          state_d     = RUN;
          waitCnt_d   = '0;
          redirPend_d = 1'b0;
          if (redirPend_q || redirect) begin
            flushAll = 1'b1;
          end else if (loadUse) begin
            luBubble = 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    memTimeout_d  = memTimeout_q || (waitCnt_d == WAIT_MAX);
    stallCycles_d = stallCycles_q;
    if ((stallAll || luBubble) && (stallCycles_q != '1)) begin
      stallCycles_d = stallCycles_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      waitCnt_q     <= '0;
      redirPend_q   <= 1'b0;
      memTimeout_q  <= 1'b0;
      stallCycles_q <= '0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      redirPend_q   <= redirPend_d;
      memTimeout_q  <= memTimeout_d;
      stallCycles_q <= stallCycles_d;
    end
  end

  // During reset both latches are forced to bubbles and nothing is held.
  assign stallPc     = reset_n && (stallAll || luBubble);
  assign stallIfId   = reset_n && (stallAll || luBubble);
  assign stallIdEx   = reset_n && stallAll;
  assign flushIfId   = !reset_n || flushAll;
  assign flushIdEx   = !reset_n || flushAll || luBubble;
  assign memTimeout  = memTimeout_q;
  assign stallCycles = stallCycles_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl with a small
//               cycle-level reference model of the stall/flush rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 6;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             idValid;
  logic [4:0]       idRs1, idRs2, exRd;
  logic             idUseRs1, idUseRs2;
  logic [1:0]       exMemOp;
  logic             dmemReady, redirect;
  logic             stallPc, stallIfId, stallIdEx, flushIfId, flushIdEx, memTimeout;
  logic [CNT_W-1:0] stallCycles;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .idValid    (idValid),
    .idRs1      (idRs1),
    .idRs2      (idRs2),
    .idUseRs1   (idUseRs1),
    .idUseRs2   (idUseRs2),
    .exMemOp    (exMemOp),
    .exRd       (exRd),
    .dmemReady  (dmemReady),
    .redirect   (redirect),
    .stallPc    (stallPc),
    .stallIfId  (stallIfId),
    .stallIdEx  (stallIdEx),
    .flushIfId  (flushIfId),
    .flushIdEx  (flushIdEx),
    .memTimeout (memTimeout),
    .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: "waiting" flag, number of busy cycles seen in the
  // current access, pending redirect, sticky timeout, stall total.
  bit m_wait, m_pend, m_tmo;
  int m_busy, m_stalls;
  bit n_wait, n_pend, n_tmo;
  int n_busy, n_stalls;
  logic [5:0]       exp_ctl;   // {stallPc,stallIfId,stallIdEx,flushIfId,flushIdEx,memTimeout}
  logic [CNT_W-1:0] exp_cnt;

  wire [5:0] act_ctl = {stallPc, stallIfId, stallIdEx, flushIfId, flushIdEx, memTimeout};

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_tmo = 0; m_busy = 0; m_stalls = 0;
  endtask

  // Compute this cycle's expected outputs and next model state, then wait
  // for the sampling point at the falling edge.
  task automatic settle();
    bit lu, busy, hold, bub, fl;
    if (!reset_n) model_reset();
    lu   = idValid && exMemOp == 2'b01 && exRd != 0 &&
           ((idUseRs1 && idRs1 == exRd) || (idUseRs2 && idRs2 == exRd));
    busy = (exMemOp == 2'b01 || exMemOp == 2'b10) && !dmemReady;
    hold = 0; bub = 0; fl = 0;
    n_wait = m_wait; n_busy = m_busy; n_pend = m_pend;
    if (!m_wait) begin
      if (busy) hold = 1;
      else if (redirect) fl = 1;
      else if (lu) bub = 1;
      n_wait = busy;
      n_busy = busy ? 1 : 0;
      n_pend = busy && redirect;
    end else if (!dmemReady) begin
      hold   = 1;
      n_busy = (m_busy + 1 > MAX_WAIT) ? MAX_WAIT : m_busy + 1;
      n_pend = m_pend || redirect;
    end else begin
      if (m_pend || redirect) fl = 1;
      else if (lu) bub = 1;
      n_wait = 0; n_busy = 0; n_pend = 0;
    end
    n_tmo    = m_tmo || (n_busy >= MAX_WAIT);
    n_stalls = (hold || bub) ? ((m_stalls + 1 > SAT) ? SAT : m_stalls + 1) : m_stalls;
    if (!reset_n) exp_ctl = 6'b000110;
    else exp_ctl = {hold || bub, hold || bub, hold, fl, fl || bub, m_tmo};
    exp_cnt = CNT_W'(m_stalls);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset_n) begin
      m_wait = n_wait; m_busy = n_busy; m_pend = n_pend;
      m_tmo = n_tmo; m_stalls = n_stalls;
    end
    #1;
  endtask

  task automatic quiet();
    reset_n = 1; idValid = 0; idRs1 = 0; idRs2 = 0; idUseRs1 = 0; idUseRs2 = 0;
    exMemOp = 2'b00; exRd = 0; dmemReady = 0; redirect = 0;
  endtask

  task automatic rand_in();
    idValid  = ($urandom_range(0, 3) != 0);
    idRs1    = 5'($urandom_range(0, 6));
    idRs2    = 5'($urandom_range(0, 6));
    idUseRs1 = 1'($urandom);
    idUseRs2 = 1'($urandom);
    exMemOp  = 2'($urandom);
    exRd     = 5'($urandom_range(0, 6));
    dmemReady = 1'($urandom);
    redirect = ($urandom_range(0, 3) == 0);
  endtask

  task automatic load_use_in(input logic [4:0] rd);
    quiet();
    idValid = 1; idRs2 = 5'd5; idUseRs2 = 1; exMemOp = 2'b01; exRd = rd; dmemReady = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rand_in(); reset_n = 0;
      settle();
      checks++;
      if (act_ctl !== 6'b000110 || stallCycles !== '0) begin
        errors++;
        $display("FAIL reset_hold: ctl=%b cnt=%0d required ctl=000110 cnt=0", act_ctl, stallCycles);
      end
      advance();
    end
    quiet();
    settle();
    checks++;
    if (act_ctl !== 6'b000000 || stallCycles !== '0) begin
      errors++;
      $display("FAIL reset_release: ctl=%b cnt=%0d required ctl=000000 cnt=0", act_ctl, stallCycles);
    end
    advance();
  endtask

  task automatic test_load_use();
    load_use_in(5'd5);
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b11001 || act_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL load_use_bubble: ctl=%b required %b", act_ctl, exp_ctl);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl !== 6'b000000 || stallCycles !== exp_cnt || exp_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL load_use_clear: ctl=%b cnt=%0d required ctl=000000 cnt=1", act_ctl, stallCycles);
    end
    advance();
    load_use_in(5'd0); idRs2 = 5'd0;
    settle();
    checks++;
    if (act_ctl !== 6'b000000) begin
      errors++;
      $display("FAIL load_use_x0: ctl=%b required 000000", act_ctl);
    end
    advance();
  endtask

  task automatic test_zero_wait();
    quiet(); exMemOp = 2'b10; dmemReady = 1;
    settle();
    checks++;
    if (act_ctl !== exp_ctl || act_ctl[5:1] !== 5'b00000) begin
      errors++;
      $display("FAIL zero_wait: ctl=%b required %b", act_ctl, exp_ctl);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl !== 6'b000000) begin
      errors++;
      $display("FAIL zero_wait_after: ctl=%b required 000000", act_ctl);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    int start;
    start = m_stalls;
    quiet(); exMemOp = 2'b10;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (act_ctl[5:1] !== 5'b11100 || act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL mem_wait_stall%0d: ctl=%b required %b", i, act_ctl, exp_ctl);
      end
      advance();
    end
    dmemReady = 1;
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b00000 || stallCycles !== CNT_W'(start + 4)) begin
      errors++;
      $display("FAIL mem_wait_ready: ctl=%b cnt=%0d required ctl=00000x cnt=%0d", act_ctl, stallCycles, start + 4);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b00000) begin
      errors++;
      $display("FAIL mem_wait_run: ctl=%b required 00000x", act_ctl);
    end
    advance();
  endtask

  task automatic test_redirect_wait();
    quiet(); exMemOp = 2'b01; exRd = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      redirect = (i == 2);
      settle();
      checks++;
      if (act_ctl[2:1] !== 2'b00 || act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL redir_wait_cycle%0d: ctl=%b required %b", i, act_ctl, exp_ctl);
      end
      advance();
    end
    redirect = 0; dmemReady = 1;
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b00011 || act_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL redir_wait_release: ctl=%b required %b", act_ctl, exp_ctl);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b00000) begin
      errors++;
      $display("FAIL redir_wait_after: ctl=%b required 00000x", act_ctl);
    end
    advance();
  endtask

  task automatic test_priority();
    load_use_in(5'd5); redirect = 1;
    settle();
    checks++;
    if (act_ctl[5:1] !== 5'b00011 || act_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL priority: ctl=%b required %b", act_ctl, exp_ctl);
    end
    advance();
  endtask

  task automatic test_saturate();
    quiet(); exMemOp = 2'b10;
    for (int i = 0; i < SAT + 6; i++) begin
      settle();
      checks++;
      if (act_ctl !== exp_ctl || stallCycles !== exp_cnt) begin
        errors++;
        $display("FAIL saturate%0d: ctl=%b cnt=%0d required ctl=%b cnt=%0d", i, act_ctl, stallCycles, exp_ctl, exp_cnt);
      end
      advance();
    end
    checks++;
    if (stallCycles !== CNT_W'(SAT)) begin
      errors++;
      $display("FAIL saturate_final: cnt=%0d required %0d", stallCycles, SAT);
    end
    dmemReady = 1;
    settle();
    advance();
  endtask

  task automatic test_timeout();
    quiet(); reset_n = 0;
    settle();
    advance();
    quiet(); exMemOp = 2'b01; exRd = 5'd7;
    for (int k = 1; k <= 6; k++) begin
      settle();
      checks++;
      if (memTimeout !== (k > MAX_WAIT) || act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL timeout_wait%0d: ctl=%b required %b", k, act_ctl, exp_ctl);
      end
      advance();
    end
    dmemReady = 1;
    settle();
    checks++;
    if (act_ctl !== 6'b000001) begin
      errors++;
      $display("FAIL timeout_ready: ctl=%b required 000001", act_ctl);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl !== 6'b000001) begin
      errors++;
      $display("FAIL timeout_sticky: ctl=%b required 000001", act_ctl);
    end
    advance();
    exMemOp = 2'b10;
    for (int k = 0; k < 2; k++) begin
      settle();
      advance();
    end
    reset_n = 0;
    settle();
    checks++;
    if (act_ctl !== 6'b000110 || stallCycles !== '0) begin
      errors++;
      $display("FAIL timeout_reset: ctl=%b cnt=%0d required ctl=000110 cnt=0", act_ctl, stallCycles);
    end
    advance();
    quiet();
    settle();
    checks++;
    if (act_ctl !== 6'b000000) begin
      errors++;
      $display("FAIL timeout_run: ctl=%b required 000000", act_ctl);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      reset_n = ($urandom_range(0, 149) != 0);
      settle();
      checks++;
      if (act_ctl !== exp_ctl || stallCycles !== exp_cnt) begin
        errors++;
        $display("FAIL random%0d: ctl=%b cnt=%0d required ctl=%b cnt=%0d", i, act_ctl, stallCycles, exp_ctl, exp_cnt);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    quiet();
    #1;
    test_reset();
    test_load_use();
    test_zero_wait();
    test_mem_wait();
    test_redirect_wait();
    test_priority();
    test_saturate();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
